// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus a 32-iteration shift-add multiplier.
// Results are registered; busy_o stalls the upstream pipeline while a multiply runs.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam logic [3:0] OpMul = 4'b0101;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] acc_next;
  logic [4:0]       shamt;

  assign shamt = data2_i[4:0];

  always_comb begin
    op_res = '0;
    case (ALUCtrl_i)
      4'b0000:                            op_res = data1_i & data2_i;
      4'b0001:                            op_res = data1_i ^ data2_i;
      4'b0010:                            op_res = data1_i << shamt;
      4'b0011, 4'b0110, 4'b1000, 4'b1001: op_res = data1_i + data2_i;
      4'b0100, 4'b1010:                   op_res = data1_i - data2_i;
      4'b0111:                            op_res = $signed(data1_i) >>> shamt;
      default:                            op_res = '0;
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (ALUCtrl_i == OpMul) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            data_d  = op_res;
            zero_d  = (op_res == '0);
            valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        // Last of the fixed 32 iterations; no early exit on a zero multiplier.
        if (cnt_q == 5'd31) begin
          data_d  = acc_next;
          zero_d  = (acc_next == '0);
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == StMul);

endmodule

// File: doc/alu_iter.md
# alu_iter

Execute-stage ALU that consumes the 4-bit ALU control code from ALU control decode, plus the two 32-bit operands, and produces a registered 32-bit result and zero flag.
- All operations except MUL complete in one cycle with back-to-back issue.
- MUL runs as a 32-iteration shift-add multiplier. While it runs, the block raises `busy_o` so the hazard/stall logic can freeze IF/ID/EX.
- The block sits between the ID/EX register (operands, ALU control code) and the EX/MEM register (result, zero).

## Interface
- `WIDTH`, 32: operand/result width; the shift amount is taken from bits [4:0].
- `clk_i`  in  1  clock; rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  an operation is presented this cycle.
- `ALUCtrl_i`  in  4  operation code (encodings below).
- `data1_i`  in  WIDTH  operand rs1.
- `data2_i`  in  WIDTH  operand rs2 or immediate.
- `data_o`  out  WIDTH  registered result; holds until the next result.
- `zero_o`  out  1  registered (result == 0); updates together with `data_o`.
- `valid_o`  out  1  one-cycle pulse: `data_o`/`zero_o` were updated this cycle.
- `busy_o`  out  1  multiply in progress; the upstream pipeline must stall.

## Operation
- Encodings (fixed):
  - AND 0000: and.
  - XOR 0001: xor.
  - SLL 0010: `data1_i << data2_i[4:0]`.
  - ADD 0011, ADDI 0110, LW 1000, SW 1001: `data1_i + data2_i`.
  - SUB 0100 and BEQ 1010: `data1_i - data2_i`.
  - MUL 0101: low 32 bits of the product.
  - SRAI 0111: `$signed(data1_i) >>> data2_i[4:0]`.
  - 1011–1111: result 0, which gives `zero_o` = 1.
- Arithmetic wraps modulo 2^32. No overflow or carry output. MUL low word is identical for signed and unsigned operands.
- State machine:
  - IDLE:
    - On `valid_i` with a non-MUL code: register the result into `data_o`/`zero_o`, pulse `valid_o`, stay in IDLE.
    - On `valid_i` with MUL: latch multiplicand = `data1_i`, multiplier = `data2_i`, acc = 0, cnt = 0; go to MUL. `valid_o` stays low.
  - MUL, each cycle:
    - If multiplier[0], acc += multiplicand.
    - multiplicand <<= 1; multiplier >>= 1; cnt += 1.
    - On the iteration with cnt == 31: write the final acc into `data_o`, compute `zero_o` from it, pulse `valid_o`, return to IDLE.
    - Always 32 iterations; no early exit.
- `busy_o` = (state == MUL), combinational from state.
- `valid_i` is ignored while in MUL. Upstream holds the instruction because `busy_o` stalls it.
- While no `valid_i` is presented, `data_o`/`zero_o` hold their last value.
- Reset (asynchronous, any time, including mid-multiply):
  - state IDLE, `data_o` 0, `zero_o` 0, `valid_o` 0, `busy_o` 0, internal registers 0.
  - An aborted multiply produces no `valid_o`.

## Timing
- Non-MUL latency:
  - Sampled at edge E0; `data_o`/`valid_o` visible after E0.
  - Throughput is one operation per cycle; consecutive `valid_i` cycles give consecutive `valid_o` pulses.
- MUL latency:
  - Accepted at E0; iterations occur at E1..E32; result and `valid_o` are visible after E32.
  - `busy_o` is high for exactly the 32 cycles between E0 and E32.
  - A new operation can be accepted at E33 (the first IDLE edge).
- `valid_o` is never high for two consecutive cycles from one MUL. It is low throughout a multiply until the final pulse.
- Release of `rst_i` is synchronised externally. The first accepting edge is the first rising edge with `rst_i` high.

## Test plan
- Reset:
  - Assert `rst_i` = 0 mid-cycle with random inputs → all outputs 0 immediately.
  - After release with `valid_i` = 0 for 5 cycles → `valid_o` stays 0.
- Single-cycle ops, back-to-back, with data1 = 0x8000_0010, data2 = 0x0000_0004:
  - ADD → 0x8000_0014; SUB → 0x8000_000C; AND → 0; XOR → 0x8000_0014.
  - SLL → 0x0000_0100; SRAI → 0xF800_0001.
  - One `valid_o` pulse per cycle, each result one cycle after its input.
- Zero flag:
  - BEQ 0x1234 vs 0x1234 → `data_o` 0, `zero_o` 1.
  - BEQ 5 vs 3 → `data_o` 2, `zero_o` 0.
  - Code 1100 → `data_o` 0, `zero_o` 1.
- MUL:
  - 7 × 6 → 42.
  - 0xFFFF_FFFF × 3 → 0xFFFF_FFFD.
  - 0x0001_0000 × 0x0001_0000 → 0.
  - For each: `busy_o` high exactly 32 cycles, `valid_o` a single pulse after E32, and `valid_i` = ADD during busy has no effect.
- MUL then ADD:
  - ADD 1 + 1 presented at E33 → `data_o` = 2 one cycle after the MUL result.
  - `data_o` holds the MUL result for exactly that one cycle in between.
- Reset mid-multiply:
  - Assert `rst_i` at iteration 10 of 7 × 6 → `busy_o` drops immediately, no `valid_o`, `data_o` 0.
  - A following ADD completes normally.
